// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with raw key detect
//
// Drives one keypad column low at a time, waits SETTLE_CYCLES for the lines
// to settle, samples the synchronized rows and locks onto the first key seen.
// No debouncing: release is reported as soon as the held row reads high.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   rows[3:0]    keypad row lines, active-low, asynchronous to clk
//   cols[3:0]    column drive, one-hot-low
//   key_code     code of the held key, kept after release
//   key_pressed  high while a key is locked and still detected

module keypad_scanner #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_pressed
);

    // One-hot state encoding so the two unused codes are detectable.
    typedef enum logic [1:0] {
        S_SCAN = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_rows_meta;
    logic [3:0]       r_rows_s;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_cols;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_held_row;
    logic [3:0]       r_key_code;
    logic             r_key_pressed;

    logic             w_any_low;
    logic [1:0]       w_low_row;
    logic [1:0]       w_col_next;
    logic [3:0]       w_cols_next;

    function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;   // '*'
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;   // '#'
            default:  code = 4'hD;   // row 3, col 3
        endcase
        return code;
    endfunction

    assign w_any_low   = (r_rows_s != 4'hF);
    assign w_col_next  = r_col_idx + 2'd1;   // natural 2-bit wrap 3 -> 0
    assign w_cols_next = ~(4'b0001 << w_col_next);

    // Lowest-index low row wins when several keys share the sampled column.
    always_comb begin
        w_low_row = 2'd3;
        if (!r_rows_s[0])      w_low_row = 2'd0;
        else if (!r_rows_s[1]) w_low_row = 2'd1;
        else if (!r_rows_s[2]) w_low_row = 2'd2;
    end

    // Two-flop synchronizer; idle value is all rows released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rows_meta <= 4'hF;
            r_rows_s    <= 4'hF;
        end else begin
            r_rows_meta <= rows;
            r_rows_s    <= r_rows_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_SCAN;
            r_col_idx     <= 2'd0;
            r_cols        <= 4'b1110;
            r_cnt         <= '0;
            r_held_row    <= 2'd0;
            r_key_code    <= 4'h0;
            r_key_pressed <= 1'b0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (r_cnt != LP_CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (w_any_low) begin
                            r_state       <= S_HOLD;
                            r_held_row    <= w_low_row;
                            r_key_code    <= f_key_map(w_low_row, r_col_idx);
                            r_key_pressed <= 1'b1;
                        end else begin
                            r_col_idx <= w_col_next;
                            r_cols    <= w_cols_next;
                        end
                    end
                end
                S_HOLD: begin
                    // Column stays frozen; only the locked row is watched.
                    if (r_rows_s[r_held_row]) begin
                        r_state       <= S_SCAN;
                        r_key_pressed <= 1'b0;
                        r_col_idx     <= w_col_next;
                        r_cols        <= w_cols_next;
                        r_cnt         <= '0;
                    end else begin
                        r_key_pressed <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_SCAN;
                    r_col_idx     <= 2'd0;
                    r_cols        <= 4'b1110;
                    r_cnt         <= '0;
                    r_key_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign cols        = r_cols;
    assign key_code    = r_key_code;
    assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner

module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_pressed;

    // Physical keypad: key_held[r*4+c] shorts row r to column c.
    logic [15:0] key_held;

    int checks;
    int failures;

    logic [3:0] col_tab [4];

    keypad_scanner #(
        .SETTLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rows       (rows),
        .cols       (cols),
        .key_code   (key_code),
        .key_pressed(key_pressed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_held[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits on negedges for key_pressed to reach val; n is the number of cycles taken.
    task automatic wait_kp(input logic val, input int limit, output int n);
        n = 0;
        while (n < limit && key_pressed !== val) begin
            @(negedge clk);
            n++;
        end
        chk("wait_kp", {7'd0, key_pressed}, {7'd0, val});
    endtask

    task automatic press(input int r, input int c, input logic [3:0] exp_code,
                         input logic [3:0] exp_cols);
        int n;
        key_held[r*4+c] = 1'b1;
        wait_kp(1'b1, 40, n);
        // 2 sync + 4*SETTLE + 1
        chk("press_latency", (n <= 19) ? 8'd1 : 8'd0, 8'd1);
        chk("press_code", {4'd0, key_code}, {4'd0, exp_code});
        chk("press_cols", {4'd0, cols}, {4'd0, exp_cols});
    endtask

    task automatic release_all(input logic [3:0] exp_code, input logic [3:0] exp_cols);
        key_held = '0;
        @(negedge clk);
        @(negedge clk);
        chk("release_still_held", {7'd0, key_pressed}, 8'd1);
        @(negedge clk);
        chk("release_kp", {7'd0, key_pressed}, 8'd0);
        chk("release_code", {4'd0, key_code}, {4'd0, exp_code});
        chk("release_cols", {4'd0, cols}, {4'd0, exp_cols});
    endtask

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        key_held   = '0;
        col_tab[0] = 4'b1110;
        col_tab[1] = 4'b1101;
        col_tab[2] = 4'b1011;
        col_tab[3] = 4'b0111;
        reset      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cols", {4'd0, cols}, 8'h0E);
        chk("rst_kp", {7'd0, key_pressed}, 8'd0);
        chk("rst_code", {4'd0, key_code}, 8'd0);
        reset = 1'b1;

        // 1. Idle scan: each column held exactly 4 cycles
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            chk("idle_cols", {4'd0, cols}, {4'd0, col_tab[(k/4)%4]});
            chk("idle_kp", {7'd0, key_pressed}, 8'd0);
        end

        // 2. Key '6' (r1,c2)
        press(1, 2, 4'h6, 4'b1011);
        repeat (10) @(negedge clk);
        chk("hold6_cols", {4'd0, cols}, 8'h0B);
        chk("hold6_kp", {7'd0, key_pressed}, 8'd1);

        // 3. Release '6': falls on the third edge, resumes at column 3
        release_all(4'h6, 4'b0111);
        repeat (3) @(negedge clk);
        chk("after6_code", {4'd0, key_code}, 8'h06);

        // 4. r0 and r2 in column 0 -> lowest row wins; then '9' is ignored
        key_held[0*4+0] = 1'b1;
        press(2, 0, 4'h1, 4'b1110);
        key_held[2*4+2] = 1'b1;
        repeat (20) @(negedge clk);
        chk("multi_code", {4'd0, key_code}, 8'h01);
        chk("multi_cols", {4'd0, cols}, 8'h0E);
        chk("multi_kp", {7'd0, key_pressed}, 8'd1);
        release_all(4'h1, 4'b1101);

        // 5. Row 3 keys, last one checks column wrap 3 -> 0
        press(3, 2, 4'hF, 4'b1011);
        release_all(4'hF, 4'b0111);
        press(3, 1, 4'h0, 4'b1101);
        release_all(4'h0, 4'b1011);
        press(3, 3, 4'hD, 4'b0111);
        release_all(4'hD, 4'b1110);

        // 6. Asynchronous reset mid-cycle during HOLD
        press(1, 1, 4'h5, 4'b1101);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_cols", {4'd0, cols}, 8'h0E);
        chk("arst_kp", {7'd0, key_pressed}, 8'd0);
        chk("arst_code", {4'd0, key_code}, 8'd0);
        key_held = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("restart_cols", {4'd0, cols}, {4'd0, col_tab[(k/4)%4]});
        end
        wait_kp(1'b0, 1, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
